// File: rtl/counter_pkg.sv
// counter_pkg
//   Shared constants and helpers for the sequential-circuits counter family.
//   - CNT_UP / CNT_DOWN : values for a counter's up input.
//   - CNT_WRAP / CNT_SAT: values for a counter's SATURATE parameter.
//   - cnt_width()       : number of bits needed to hold a terminal value, for
//                         callers that derive WIDTH from MAX.
package counter_pkg;

  localparam logic CNT_UP   = 1'b1;
  localparam logic CNT_DOWN = 1'b0;

  localparam int CNT_WRAP = 0;
  localparam int CNT_SAT  = 1;

  // Bits required to represent max_val (at least one bit, so MAX=0 still
  // gets a legal one-bit counter).
  function automatic int cnt_width(input int max_val);
    int w;
    w = 1;
    while ((max_val >> w) != 0) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/mod_counter_step.sv
// mod_counter_step
//   Purely combinational next-count logic for a modulo MAX+1 up/down counter.
//   Ports:
//     i_cur    in  WIDTH  current count
//     i_up     in  1      direction (1 = increment, 0 = decrement)
//     o_next   out WIDTH  count after one enabled step
//     o_at_end out 1      current count sits at the end in the chosen direction
module mod_counter_step
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX      = 2**WIDTH - 1,
  parameter int SATURATE = CNT_WRAP
) (
  input  logic [WIDTH-1:0] i_cur,
  input  logic             i_up,
  output logic [WIDTH-1:0] o_next,
  output logic             o_at_end
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  always_comb begin
    o_next   = i_cur;
    o_at_end = 1'b0;
    // ">=" rather than "==" so an out-of-range code can never run away
    // past MAX; loads are clamped so this is purely defensive.
    if (i_up == CNT_UP) begin
      o_at_end = (i_cur >= MAX_V);
    end else begin
      o_at_end = (i_cur == '0);
    end

    if (o_at_end) begin
      if (SATURATE == CNT_SAT) begin
        o_next = i_cur;
      end else if (i_up == CNT_UP) begin
        o_next = '0;
      end else begin
        o_next = MAX_V;
      end
    end else if (i_up == CNT_UP) begin
      o_next = i_cur + WIDTH'(1);
    end else begin
      o_next = i_cur - WIDTH'(1);
    end
  end

endmodule

// File: rtl/mod_updown_counter.sv
// mod_updown_counter
//   Synchronous modulo MAX+1 up/down counter with load, enable, wrap or
//   saturate at the ends, and cascade outputs. All state changes on the
//   rising edge of clk; reset is synchronous, active-high, highest priority.
//   Ports:
//     clk      in  1      clock
//     reset    in  1      synchronous reset (out<=0, wrapped<=0)
//     en       in  1      count enable / cascade input from lower stage tc
//     up       in  1      direction (1 = up, 0 = down)
//     load     in  1      parallel load strobe (beats en)
//     load_val in  WIDTH  value to load, clamped to MAX
//     out      out WIDTH  current count
//     tc       out 1      combinational terminal count, feeds next stage en
//     wrapped  out 1      one-cycle pulse after a wrap or saturation event
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX      = 2**WIDTH - 1,
  parameter int SATURATE = CNT_WRAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             wrapped
);

  localparam longint          FULL_MAX = (longint'(1) << WIDTH) - 1;
  localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX);

  if (WIDTH < 1 || MAX < 0 || longint'(MAX) > FULL_MAX) begin : g_bad_params
    $error("mod_updown_counter: illegal WIDTH/MAX combination");
  end

  logic [WIDTH-1:0] r_count;
  logic             r_wrapped;
  logic [WIDTH-1:0] w_next;
  logic             w_at_end;
  logic [WIDTH-1:0] w_load_clamped;

  mod_counter_step #(
    .WIDTH    (WIDTH),
    .MAX      (MAX),
    .SATURATE (SATURATE)
  ) u_step (
    .i_cur    (r_count),
    .i_up     (up),
    .o_next   (w_next),
    .o_at_end (w_at_end)
  );

  // With a full-range modulus every code is legal, so no clamp is needed
  // (and the comparison would be constant).
  if (longint'(MAX) == FULL_MAX) begin : g_no_clamp
    assign w_load_clamped = load_val;
  end else begin : g_clamp
    assign w_load_clamped = (load_val > MAX_V) ? MAX_V : load_val;
  end

  // State register: reset > load > en > hold
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count   <= '0;
      r_wrapped <= 1'b0;
    end else if (load) begin
      r_count   <= w_load_clamped;
      r_wrapped <= 1'b0;
    end else if (en) begin
      r_count   <= w_next;
      r_wrapped <= w_at_end;
    end else begin
      r_wrapped <= 1'b0;
    end
  end

  assign out     = r_count;
  assign wrapped = r_wrapped;
  // Unregistered so a cascaded upper stage steps on the same edge the lower
  // stage wraps.
  assign tc      = en & w_at_end;

endmodule

// File: tb/tb_mod_updown_counter.sv
module tb_mod_updown_counter;
  import counter_pkg::*;

  localparam int W = 4;
  localparam int M = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Wrap-mode instance
  logic         a_reset, a_en, a_up, a_load;
  logic [W-1:0] a_lv, a_out;
  logic         a_tc, a_wr;
  // Saturate-mode instance
  logic         s_reset, s_en, s_up, s_load;
  logic [W-1:0] s_lv, s_out;
  logic         s_tc, s_wr;
  // Cascaded pair
  logic         c_reset, c_en, c_up, c_load;
  logic [W-1:0] c_lv, cl_out, ch_out;
  logic         cl_tc, ch_tc, cl_wr, ch_wr;

  mod_updown_counter #(.WIDTH(W), .MAX(M), .SATURATE(CNT_WRAP)) u_a (
    .clk(clk), .reset(a_reset), .en(a_en), .up(a_up), .load(a_load),
    .load_val(a_lv), .out(a_out), .tc(a_tc), .wrapped(a_wr));

  mod_updown_counter #(.WIDTH(W), .MAX(M), .SATURATE(CNT_SAT)) u_s (
    .clk(clk), .reset(s_reset), .en(s_en), .up(s_up), .load(s_load),
    .load_val(s_lv), .out(s_out), .tc(s_tc), .wrapped(s_wr));

  mod_updown_counter #(.WIDTH(W), .MAX(M), .SATURATE(CNT_WRAP)) u_lo (
    .clk(clk), .reset(c_reset), .en(c_en), .up(c_up), .load(c_load),
    .load_val(c_lv), .out(cl_out), .tc(cl_tc), .wrapped(cl_wr));

  mod_updown_counter #(.WIDTH(W), .MAX(M), .SATURATE(CNT_WRAP)) u_hi (
    .clk(clk), .reset(c_reset), .en(cl_tc), .up(c_up), .load(c_load),
    .load_val(c_lv), .out(ch_out), .tc(ch_tc), .wrapped(ch_wr));

  typedef struct {
    bit         dut;   // 0 = wrap instance, 1 = saturate instance
    bit         rst, en, up, ld;
    logic [3:0] lv;
    logic [3:0] eo;
    bit         etc, ewr;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic addv(input bit dut, input bit rst, input bit en, input bit up,
                      input bit ld, input int lv, input int eo, input bit etc,
                      input bit ewr);
    vec_t v;
    v.dut = dut; v.rst = rst; v.en = en; v.up = up; v.ld = ld;
    v.lv = 4'(lv); v.eo = 4'(eo); v.etc = etc; v.ewr = ewr;
    vq.push_back(v);
  endtask

  task automatic idle_inputs();
    a_reset = 0; a_en = 0; a_up = 0; a_load = 0; a_lv = '0;
    s_reset = 0; s_en = 0; s_up = 0; s_load = 0; s_lv = '0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [W-1:0] o;
    logic t, wr;
    idle_inputs();
    if (v.dut == 1'b0) begin
      a_reset = v.rst; a_en = v.en; a_up = v.up; a_load = v.ld; a_lv = v.lv;
    end else begin
      s_reset = v.rst; s_en = v.en; s_up = v.up; s_load = v.ld; s_lv = v.lv;
    end
    @(posedge clk); #1;
    o  = v.dut ? s_out : a_out;
    t  = v.dut ? s_tc  : a_tc;
    wr = v.dut ? s_wr  : a_wr;
    n_vec++;
    if (o !== v.eo || t !== v.etc || wr !== v.ewr) begin
      n_err++;
      $display("FAIL vec%0d dut%0d: out=%0d tc=%0d wrapped=%0d, want out=%0d tc=%0d wrapped=%0d",
               idx, v.dut, o, t, wr, v.eo, v.etc, v.ewr);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b, want %0b", name, act, exp);
    end
  endtask

  initial begin
    idle_inputs();
    c_reset = 0; c_en = 0; c_up = 1; c_load = 0; c_lv = '0;

    // ---- wrap instance: dut rst en up ld lv | out tc wr ----
    addv(0, 1,1,1,0, 0,  0,0,0);
    for (int i = 1; i <= 9; i++) addv(0, 0,1,1,0, 0, i, (i == 9), 0);
    addv(0, 0,1,1,0, 0,  0,0,1);          // 9 -> 0 wrap
    addv(0, 0,1,1,0, 0,  1,0,0);
    addv(0, 0,1,1,0, 0,  2,0,0);
    addv(0, 0,1,0,0, 0,  1,0,0);          // down
    addv(0, 0,1,0,0, 0,  0,1,0);
    addv(0, 0,1,0,0, 0,  9,0,1);          // 0 -> 9 wrap
    addv(0, 0,1,0,0, 0,  8,0,0);
    addv(0, 0,0,0,0, 0,  8,0,0);          // hold
    addv(0, 0,0,1,0, 0,  8,0,0);
    addv(0, 0,0,0,1, 13, 9,0,0);          // clamped load
    addv(0, 0,1,1,1, 4,  4,0,0);          // load beats en
    addv(0, 0,0,0,1, 9,  9,0,0);
    addv(0, 0,1,1,0, 0,  0,0,1);
    addv(0, 0,1,0,0, 0,  9,0,1);
    addv(0, 0,1,0,1, 0,  0,1,0);          // load at end: no wrapped pulse
    addv(0, 0,0,0,0, 0,  0,0,0);
    addv(0, 1,1,1,1, 5,  0,0,0);          // reset beats load
    for (int i = 1; i <= 5; i++) addv(0, 0,1,1,0, 0, i, 0, 0);
    addv(0, 1,1,1,0, 0,  0,0,0);          // reset mid-count
    addv(0, 0,1,1,0, 0,  1,0,0);          // resumes at 1
    addv(0, 0,0,0,1, 9,  9,0,0);
    addv(0, 1,1,1,0, 0,  0,0,0);          // reset coincident with wrap
    addv(0, 0,0,0,0, 0,  0,0,0);
    // ---- saturate instance ----
    addv(1, 1,0,0,0, 0,  0,0,0);
    addv(1, 0,0,0,1, 7,  7,0,0);
    addv(1, 0,1,1,0, 0,  8,0,0);
    addv(1, 0,1,1,0, 0,  9,1,0);
    addv(1, 0,1,1,0, 0,  9,1,1);
    addv(1, 0,1,1,0, 0,  9,1,1);
    addv(1, 0,1,0,0, 0,  8,0,0);
    addv(1, 0,0,0,1, 1,  1,0,0);
    addv(1, 0,1,0,0, 0,  0,1,0);
    addv(1, 0,1,0,0, 0,  0,1,1);
    addv(1, 0,1,0,0, 0,  0,1,1);
    addv(1, 0,0,0,0, 0,  0,0,0);
    addv(1, 0,0,1,1, 15, 9,0,0);
    addv(1, 0,1,1,0, 0,  9,1,1);

    foreach (vq[i]) run_vec(i, vq[i]);

    // tc follows en/up combinationally, no edge needed (wrap instance at 0)
    idle_inputs();
    #1;
    a_en = 1; a_up = 0; #1;
    check_bit("tc_down_at_0", a_tc, 1'b1);
    a_up = 1; #1;
    check_bit("tc_up_at_0", a_tc, 1'b0);
    a_en = 0; a_up = 0; #1;
    check_bit("tc_en0", a_tc, 1'b0);

    // ---- cascaded pair, 100 clocks up ----
    c_reset = 1; c_en = 1; c_up = 1;
    @(posedge clk); #1;
    n_vec++;
    if (cl_out !== 4'd0 || ch_out !== 4'd0 || cl_wr !== 1'b0 || ch_wr !== 1'b0) begin
      n_err++;
      $display("FAIL casc_reset: hi=%0d lo=%0d wr=%0b%0b, want 0 0 wr=00",
               ch_out, cl_out, ch_wr, cl_wr);
    end
    c_reset = 0;
    for (int k = 1; k <= 100; k++) begin
      int el, eh;
      bit ewl, ewh, etl, eth;
      @(posedge clk); #1;
      el  = k % 10;
      eh  = (k / 10) % 10;
      ewl = (el == 0);
      ewh = ((k % 100) == 0);
      etl = (el == 9);
      eth = etl && (eh == 9);
      n_vec++;
      if (cl_out !== 4'(el) || ch_out !== 4'(eh) || cl_wr !== ewl || ch_wr !== ewh ||
          cl_tc !== etl || ch_tc !== eth) begin
        n_err++;
        $display("FAIL casc_k%0d: hi=%0d lo=%0d wr=%0b%0b tc=%0b%0b, want hi=%0d lo=%0d wr=%0b%0b tc=%0b%0b",
                 k, ch_out, cl_out, ch_wr, cl_wr, ch_tc, cl_tc,
                 eh, el, ewh, ewl, eth, etl);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
